// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with debounce and a one-cycle key strobe
// Auto-repeat of a held key is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scan #(
  parameter int SCAN_DIV     = 5000,
  parameter int DEBOUNCE_CNT = 100000,
  parameter int REPEAT_CNT   = 25000000
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CNT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       row_meta_q, row_meta_d;
  logic [3:0]       row_s_q, row_s_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;
  logic [1:0]       low_row;
  logic             row_hit;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CNT);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`else
  // REPEAT_CNT has no effect unless auto-repeat is built.
  if (REPEAT_CNT < 2) begin : g_no_repeat
  end
`endif

  // Lowest-numbered low row wins when several keys share the driven column.
  always_comb begin
    low_row = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s_q[i]) low_row = 2'(i);
    end
  end

  assign row_hit = ~row_s_q[row_idx_q];

  always_comb begin
    state_d     = state_q;
    row_meta_d  = row;
    row_s_d     = row_meta_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    div_d       = div_q;
    deb_d       = deb_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = '0;
`endif
    unique case (state_q)
      S_SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (row_s_q == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = low_row;
            deb_d     = '0;
            state_d   = S_DEBOUNCE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DEBOUNCE: begin
        if (!row_hit) begin
          div_d   = '0;
          state_d = S_SCAN;
        end else if (deb_q == DEB_LAST) begin
          key_code_d  = {row_idx_q, col_idx_q};
          key_valid_d = 1'b1;
          key_down_d  = 1'b1;
          state_d     = S_PRESSED;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
      S_PRESSED: begin
        if (!row_hit) begin
          deb_d   = '0;
          state_d = S_RELEASE;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep_q == REP_LAST) begin
          key_valid_d = 1'b1;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
`endif
      end
      S_RELEASE: begin
        if (row_hit) begin
          deb_d   = '0;
          state_d = S_PRESSED;
        end else if (deb_q == DEB_LAST) begin
          key_down_d = 1'b0;
          col_idx_d  = col_idx_q + 2'd1;
          div_d      = '0;
          state_d    = S_SCAN;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
      default: state_d = S_SCAN;
    endcase
    col_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q     <= S_SCAN;
      row_meta_q  <= 4'hF;
      row_s_q     <= 4'hF;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      div_q       <= '0;
      deb_q       <= '0;
      col_q       <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_meta_q  <= row_meta_d;
      row_s_q     <= row_s_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      div_q       <= div_d;
      deb_q       <= deb_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - keypad_scan bench: keypad model, behavioural reference, directed and random presses
// Repeat expectations follow KEYPAD_REPEAT_EN.
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int REP      = 32;

  localparam int P_IDLE    = 0;
  localparam int P_CONFIRM = 1;
  localparam int P_HELD    = 2;
  localparam int P_LETGO   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_s1, m_s2, m_code;
  int         m_col, m_row, m_tick, m_run, m_rep, m_phase;
  logic       m_valid, m_down;

  int         strobes;
  logic [3:0] last_code;
  logic       saw_valid;
  logic       prev_valid;

  keypad_scan #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEB),
    .REPEAT_CNT  (REP)
  ) dut (
    .clkin    (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && (col[c] === 1'b0)) row[r] = 1'b0;
      end
    end
  end

  function automatic logic [3:0] col_of(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  function automatic int lowest_low(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: one call per rising edge with the row and reset levels seen before that edge.
  task automatic model_step(input logic [3:0] r_now, input logic rst_now);
    logic [3:0] rs;
    if (!rst_now) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_phase = P_IDLE; m_col = 0; m_row = 0;
      m_tick = 0; m_run = 0; m_rep = 0; m_code = 4'h0; m_valid = 1'b0; m_down = 1'b0;
      return;
    end
    rs = m_s2;
    m_s2 = m_s1;
    m_s1 = r_now;
    m_valid = 1'b0;
    case (m_phase)
      P_IDLE: begin
        m_tick++;
        if (m_tick == SCAN_DIV) begin
          m_tick = 0;
          if (rs == 4'hF) m_col = (m_col + 1) % 4;
          else begin
            m_row = lowest_low(rs);
            m_run = 0;
            m_phase = P_CONFIRM;
          end
        end
      end
      P_CONFIRM: begin
        if (rs[m_row]) begin
          m_phase = P_IDLE;
          m_tick = 0;
        end else begin
          m_run++;
          if (m_run == DEB) begin
            m_code = 4'(4 * m_row + m_col);
            m_valid = 1'b1;
            m_down = 1'b1;
            m_rep = 0;
            m_phase = P_HELD;
          end
        end
      end
      P_HELD: begin
        if (rs[m_row]) begin
          m_run = 0;
          m_phase = P_LETGO;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          m_rep++;
          if (m_rep == REP) begin
            m_valid = 1'b1;
            m_rep = 0;
          end
`endif
        end
      end
      default: begin
        if (!rs[m_row]) begin
          m_rep = 0;
          m_phase = P_HELD;
        end else begin
          m_run++;
          if (m_run == DEB) begin
            m_down = 1'b0;
            m_col = (m_col + 1) % 4;
            m_tick = 0;
            m_phase = P_IDLE;
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    logic [3:0] r_now;
    logic       rst_now;
    @(negedge clk);
    r_now = row;
    rst_now = rst_n;
    @(posedge clk);
    model_step(r_now, rst_now);
    #1;
    check("col", 32'(col), 32'(col_of(m_col)));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_down", 32'(key_down), 32'(m_down));
    check("key_code", 32'(key_code), 32'(m_code));
    saw_valid = (key_valid === 1'b1);
    if (saw_valid) begin
      check("valid_gap", 32'(prev_valid), 32'(0));
      strobes++;
      last_code = key_code;
    end
    prev_valid = saw_valid;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_strobe(input string tag, input int budget);
    saw_valid = 1'b0;
    for (int i = 0; i < budget && !saw_valid; i++) tick();
    check(tag, 32'(saw_valid), 32'(1));
  endtask

  task automatic wait_release(input string tag, input int budget);
    for (int i = 0; i < budget && key_down === 1'b1; i++) tick();
    check(tag, 32'(key_down), 32'(0));
  endtask

  initial begin
    keys = 16'h0;
    rst_n = 1'b0;
    strobes = 0;
    last_code = 4'h0;
    saw_valid = 1'b0;
    prev_valid = 1'b0;

    // Reset state
    ticks(2);
    check("rst_col", 32'(col), 32'(4'b1110));
    check("rst_code", 32'(key_code), 32'(4'h0));
    check("rst_valid", 32'(key_valid), 32'(0));
    check("rst_down", 32'(key_down), 32'(0));

    // Idle sweep: every column held for SCAN_DIV cycles
    rst_n = 1'b1;
    for (int k = 1; k < 40; k++) begin
      tick();
      check("idle_sweep", 32'(col), 32'(col_of((k / SCAN_DIV) % 4)));
    end
    check("idle_strobes", 32'(strobes), 32'(0));

    // Clean press of (2,1)
    strobes = 0;
    keys[9] = 1'b1;
    ticks(60);
    keys = 16'h0;
    wait_release("clean_release", 60);
    check("clean_strobes", 32'(strobes), 32'(1));
    check("clean_code", 32'(last_code), 32'(4'h9));
    check("clean_next_col", 32'(col), 32'(4'b1011));

    // Bounce on (1,3): low 3, high 2, low 3, released
    for (int i = 0; i < 40 && !(m_col == 3 && m_tick == 0 && m_phase == P_IDLE); i++) tick();
    check("bounce_align", 32'(col), 32'(4'b0111));
    strobes = 0;
    keys[7] = 1'b1; ticks(3);
    keys[7] = 1'b0; ticks(2);
    keys[7] = 1'b1; ticks(3);
    keys[7] = 1'b0; ticks(3);
    check("bounce_col", 32'(col), 32'(4'b0111));
    ticks(10);
    check("bounce_strobes", 32'(strobes), 32'(0));
    check("bounce_code", 32'(key_code), 32'(4'h9));

    // Two keys in column 0: lowest row wins, releasing the other has no effect
    strobes = 0;
    keys[4] = 1'b1;
    keys[12] = 1'b1;
    wait_strobe("dual_strobe", 60);
    check("dual_code", 32'(key_code), 32'(4'h4));
    ticks(15);
    keys[12] = 1'b0;
    ticks(20);
    check("dual_hold", 32'(key_down), 32'(1));
    keys[4] = 1'b0;
    wait_release("dual_release", 40);
    check("dual_strobes", 32'(strobes), 32'(1));

    // Reset while (0,2) is held
    keys[2] = 1'b1;
    wait_strobe("rst_hold_strobe", 60);
    ticks(5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_hold_down", 32'(key_down), 32'(0));
    check("rst_hold_code", 32'(key_code), 32'(4'h0));
    check("rst_hold_col", 32'(col), 32'(4'b1110));
    wait_strobe("redetect_strobe", 60);
    check("redetect_code", 32'(key_code), 32'(4'h2));
    keys = 16'h0;
    wait_release("redetect_release", 40);

    // (3,3) held 100 cycles after acceptance
    keys[15] = 1'b1;
    wait_strobe("rep_first", 80);
    check("rep_code", 32'(key_code), 32'(4'hF));
    strobes = 0;
    ticks(100);
`ifdef KEYPAD_REPEAT_EN
    check("rep_strobes", 32'(strobes), 32'(3));
`else
    check("rep_strobes", 32'(strobes), 32'(0));
`endif
    check("rep_code_hold", 32'(last_code), 32'(4'hF));
    keys = 16'h0;
    wait_release("rep_release", 40);

    // Random presses, chords and short taps against the reference
    for (int n = 0; n < 16; n++) begin
      int k1, k2, hold;
      k1 = $urandom_range(0, 15);
      k2 = $urandom_range(0, 15);
      hold = $urandom_range(1, 45);
      ticks($urandom_range(0, 20));
      keys[k1] = 1'b1;
      if ($urandom_range(0, 2) == 0) keys[k2] = 1'b1;
      ticks(hold);
      if ($urandom_range(0, 1) == 0) begin
        keys = 16'h0;
        ticks($urandom_range(1, 6));
        keys[k1] = 1'b1;
        ticks($urandom_range(1, 12));
      end
      keys = 16'h0;
      wait_release("rand_release", 60);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
